sha3_block_padder: RTL

- Sequential successor to the combinational 64-bit SHA-3 word padder.
- Accepts message words (up to 8 bytes each, first byte in bits 63:56) and assembles them into a full rate block of RATE_WORDS×64 bits.
- Applies the domain-separation byte and the final 0x80 bit, and generates any zero-fill and extra padding blocks itself.
- Presents each completed block to the permutation core (f_permutation) with a ready/ack handshake.

---
 rtl/sha3_block_padder_if.sv | 42 ++++
 rtl/sha3_block_padder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sha3_block_padder_if.sv
// rtl/sha3_block_padder_if.sv - message-word and rate-block handshake bundle for sha3_block_padder
//
// Purpose: groups the message-word input stream and the assembled-block output
// toward the permutation core into one interface.
//
// Signals:
//   in        [63:0]              message word, byte 0 in [63:56]
//   in_ready                      in holds a valid word this cycle
//   is_last                       current word is the final message word
//   byte_num  [2:0]               valid bytes in a final word (0..7)
//   in_rdy                        padder can take a word this cycle
//   out       [64*RATE_WORDS-1:0] assembled block, word 0 in the MS 64 bits
//   out_ready                     out holds a complete block
//   f_ack                         permutation core has consumed out
//   shake                         (SHA3_PADDER_SHAKE_EN only) use 8'h1F separator
//
// Modports: master = message source / core side, slave = padder side.
interface sha3_block_padder_if #(
  parameter int RATE_WORDS = 17
);
  logic [63:0]              in;
  logic                     in_ready;
  logic                     is_last;
  logic [2:0]               byte_num;
  logic                     in_rdy;
  logic [64*RATE_WORDS-1:0] out;
  logic                     out_ready;
  logic                     f_ack;
`ifdef SHA3_PADDER_SHAKE_EN
  logic                     shake;

  modport master (output in, in_ready, is_last, byte_num, f_ack, shake,
                  input  in_rdy, out, out_ready);
  modport slave  (input  in, in_ready, is_last, byte_num, f_ack, shake,
                  output in_rdy, out, out_ready);
`else
  modport master (output in, in_ready, is_last, byte_num, f_ack,
                  input  in_rdy, out, out_ready);
  modport slave  (input  in, in_ready, is_last, byte_num, f_ack,
                  output in_rdy, out, out_ready);
`endif
endinterface

// File: rtl/sha3_block_padder.sv
// rtl/sha3_block_padder.sv - assembles message words into padded SHA-3 rate blocks
//
// Purpose: shifts message words into a RATE_WORDS x 64-bit block, inserts the
// domain-separation byte after the last message byte, sets the final 0x80 bit,
// zero-fills the rest of the block (or a whole extra block) and hands each
// complete block to the permutation core with an out_ready / f_ack handshake.
// One message is processed per reset.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    sha3_block_padder_if.slave (word input stream and block output)
//
// Parameters:
//   RATE_WORDS  64-bit words per rate block (2..21)
//   DSEP        domain-separation byte
//
// Optional feature (macro SHA3_PADDER_SHAKE_EN): bus.shake, sampled with the
// final word, selects 8'h1F as separator instead of DSEP.
module sha3_block_padder #(
  parameter int         RATE_WORDS = 17,
  parameter logic [7:0] DSEP       = 8'h06
) (
  input logic              clk,
  input logic              reset,
  sha3_block_padder_if.slave bus
);

  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATE_WORDS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(RATE_WORDS);

  typedef enum logic [1:0] {ACCEPT, PAD, FULL, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            count;
  logic [64*RATE_WORDS-1:0] out_q;
  logic                     out_ready_q;
  logic                     in_rdy_q;
  logic                     finished;

  logic [7:0]  sep;
  logic [63:0] keep_mask;
  logic [63:0] sep_word;
  logic [63:0] last_word;
  logic [63:0] word;
  logic [63:0] pad_word;

  // Final-word formatting: keep the byte_num leading bytes, place the
  // separator right behind them, and fold in the 0x80 bit when this word
  // also closes the block.
  always_comb begin
`ifdef SHA3_PADDER_SHAKE_EN
    sep = bus.shake ? 8'h1F : DSEP;
`else
    sep = DSEP;
`endif
    keep_mask = ~({64{1'b1}} >> {bus.byte_num, 3'b000});
    sep_word  = {56'd0, sep} << {(3'd7 - bus.byte_num), 3'b000};
    last_word = (bus.in & keep_mask) | sep_word;
    if (count == LAST_SLOT) begin
      last_word[7:0] = last_word[7:0] | 8'h80;
    end
    word     = bus.is_last ? last_word : bus.in;
    pad_word = (count == LAST_SLOT) ? 64'h80 : 64'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ACCEPT;
      count       <= '0;
      out_q       <= '0;
      out_ready_q <= 1'b0;
      in_rdy_q    <= 1'b0;
      finished    <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_rdy_q && bus.in_ready) begin
            out_q <= {out_q[64*RATE_WORDS-65:0], word};
            count <= count + 1'b1;
            if (bus.is_last) begin
              finished <= 1'b1;
            end
            if (count == LAST_SLOT) begin
              state       <= FULL;
              out_ready_q <= 1'b1;
              in_rdy_q    <= 1'b0;
            end else if (bus.is_last) begin
              state    <= PAD;
              in_rdy_q <= 1'b0;
            end else begin
              in_rdy_q <= 1'b1;
            end
          end else begin
            // Also raises in_rdy on the first cycle out of reset.
            in_rdy_q <= (count < FULL_CNT);
          end
        end

        PAD: begin
          out_q <= {out_q[64*RATE_WORDS-65:0], pad_word};
          count <= count + 1'b1;
          if (count == LAST_SLOT) begin
            state       <= FULL;
            out_ready_q <= 1'b1;
          end
        end

        FULL: begin
          // out_q is left intact; the next block simply shifts over it.
          if (bus.f_ack) begin
            count       <= '0;
            out_ready_q <= 1'b0;
            if (finished) begin
              state    <= DONE;
              in_rdy_q <= 1'b0;
            end else begin
              state    <= ACCEPT;
              in_rdy_q <= 1'b1;
            end
          end
        end

        default: begin
          in_rdy_q    <= 1'b0;
          out_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ready = out_ready_q;
  assign bus.in_rdy    = in_rdy_q;

endmodule
